// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared state encoding for the multi-cycle sequencer
package cpu_seq_pkg;
  localparam int ST_W = 3;
  typedef enum logic [ST_W-1:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd7
  } state_t;
endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: memory handshakes, decoder intent and datapath strobes
interface cpu_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic ir_load;
  logic dec_valid;
  logic dec_regwrite;
  logic dec_memwrite;
  logic dec_is_load;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;
  logic rf_we;
  logic pc_en;
  modport master (
    output imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en,
    input  imem_ack, dmem_ack, dec_valid, dec_regwrite, dec_memwrite, dec_is_load
  );
  modport slave (
    input  imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en,
    output imem_ack, dmem_ack, dec_valid, dec_regwrite, dec_memwrite, dec_is_load
  );
endinterface

// File: rtl/cpu_sequencer_seq_watchdog.sv
// seq_watchdog: wait-cycle counter that flags when MEM_TIMEOUT is reached
module seq_watchdog #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int W = $clog2(MEM_TIMEOUT + 2);
  logic [W-1:0] cnt;
  assign timeout = en && cnt == W'(MEM_TIMEOUT);
  // count waiting cycles, holding at the limit so it never wraps
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en && !timeout) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control with debug run/step/halt
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  cpu_sequencer_if.master  bus,
  output logic             busy,
  output logic             err,
  output logic [ST_W-1:0]  state,
  output logic [CNT_W-1:0] retired
);
  state_t st, nxt;
  logic step_mode, halt_pend, waiting, timeout;
  assign waiting      = st == FETCH || st == MEM;
  assign bus.imem_req = st == FETCH;
  assign bus.ir_load  = st == FETCH && bus.imem_ack;
  assign bus.dmem_req = st == MEM;
  assign bus.dmem_we  = st == MEM && bus.dec_memwrite;
  assign bus.rf_we    = st == WB && bus.dec_regwrite && !bus.dec_memwrite;
  assign bus.pc_en    = st == WB;
  assign busy         = st != IDLE && st != ERR;
  assign err          = st == ERR;
  assign state        = st;
  seq_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (!waiting),
    .en      (waiting),
    .timeout (timeout)
  );
  // state register, debug mode flags and retirement counter
  always_ff @(posedge clk)
    if (rst) begin
      st        <= IDLE;
      step_mode <= 1'b0;
      halt_pend <= 1'b0;
      retired   <= '0;
    end else begin
      st <= nxt;
      if (st == IDLE && (run || step)) step_mode <= !run;
      else if (st == WB && nxt == IDLE) step_mode <= 1'b0;
      if (st == WB) halt_pend <= 1'b0;
      else if (busy && halt_req) halt_pend <= 1'b1;
      if (st == WB) retired <= retired + 1'b1;
    end
  // next-state decode; ack beats timeout in the same cycle
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = (run || step) ? FETCH : IDLE;
      FETCH:   nxt = bus.imem_ack ? DECODE : timeout ? ERR : FETCH;
      DECODE:  nxt = (!bus.dec_valid || (bus.dec_memwrite && bus.dec_is_load)) ? ERR : EXEC;
      EXEC:    nxt = (bus.dec_memwrite || bus.dec_is_load) ? MEM : WB;
      MEM:     nxt = bus.dmem_ack ? WB : timeout ? ERR : MEM;
      WB:      nxt = (halt_pend || halt_req || step_mode) ? IDLE : FETCH;
      default: nxt = ERR;
    endcase
  end
endmodule
